// File: rtl/sat_mon_pkg.sv
// Shared definitions for the saturating-counter monitor: FSM states,
// sticky error codes and default geometry of the upstream counter.
package sat_mon_pkg;

  // Monitor phase; encoding is visible on the state output port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    SAT  = 2'd2,
    ERR  = 2'd3
  } mon_state_t;

  // Sticky error causes reported on err_code.
  localparam logic [1:0] ERR_NONE  = 2'd0;  // no violation seen
  localparam logic [1:0] ERR_RANGE = 2'd1;  // value above LIMIT while ramping
  localparam logic [1:0] ERR_STEP  = 2'd2;  // ramp skipped or repeated a value
  localparam logic [1:0] ERR_LEAVE = 2'd3;  // left LIMIT without restarting at 0

  // Defaults matching the upstream 11-bit counter that saturates at 200.
  localparam int DEF_W       = 11;
  localparam int DEF_LIMIT   = 200;
  localparam int DEF_DWELL_W = 16;

endpackage

// File: rtl/sat_dwell_counter.sv
// Dwell-time counter: counts enabled cycles, holds at all-ones, and has a
// synchronous clear that beats the enable.
module sat_dwell_counter #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [DWELL_W-1:0] cnt
);

  // Saturating increment; clear has priority so a re-entry starts at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (en && (cnt != '1))     cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/sat_count_monitor.sv
// Checker for a saturating up-counter stage. Follows the sampled value
// through ramp and saturation, pulses on saturation entry, measures dwell
// at the limit and latches the first protocol violation until cleared.
module sat_count_monitor
  import sat_mon_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int LIMIT   = DEF_LIMIT,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [W-1:0]       c_in,
  output logic [1:0]         state,
  output logic               sat_pulse,
  output logic [DWELL_W-1:0] dwell_cnt,
  output logic               err,
  output logic [1:0]         err_code
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  mon_state_t   st, nxt_st;
  logic [W-1:0] prev_c;
  logic         nxt_err, nxt_pulse;
  logic [1:0]   nxt_code;
  logic         dw_clr, dw_en;

  // Sample classification. The successor is formed one bit wider so an
  // all-ones previous value has no legal successor instead of wrapping to 0.
  logic [W:0]   prev_inc;
  logic         is_zero, is_lim, is_over, is_step;

  assign prev_inc = {1'b0, prev_c} + 1'b1;
  assign is_zero  = (c_in == '0);
  assign is_lim   = (c_in == LIM);
  assign is_over  = (c_in > LIM);
  assign is_step  = ({1'b0, c_in} == prev_inc);

  // Next-state and error decision; clear overrides any transition or error.
  always_comb begin
    nxt_st    = st;
    nxt_err   = err;
    nxt_code  = err_code;
    nxt_pulse = 1'b0;
    dw_clr    = 1'b0;
    dw_en     = 1'b0;
    if (clr) begin
      nxt_st   = IDLE;
      nxt_err  = 1'b0;
      nxt_code = ERR_NONE;
      dw_clr   = 1'b1;
    end else begin
      case (st)
        IDLE: begin
          if (is_zero) nxt_st = RAMP;
        end
        RAMP: begin
          if (is_zero) begin
            nxt_st = RAMP;                 // upstream restarted
          end else if (is_over) begin
            nxt_st   = ERR;                // range beats step
            nxt_err  = 1'b1;
            nxt_code = ERR_RANGE;
          end else if (is_step && is_lim) begin
            nxt_st    = SAT;
            nxt_pulse = 1'b1;
            dw_clr    = 1'b1;
          end else if (is_step) begin
            nxt_st = RAMP;
          end else begin
            nxt_st   = ERR;
            nxt_err  = 1'b1;
            nxt_code = ERR_STEP;
          end
        end
        SAT: begin
          if (is_lim) begin
            dw_en = 1'b1;
          end else if (is_zero) begin
            nxt_st = RAMP;
            dw_clr = 1'b1;
          end else begin
            nxt_st   = ERR;                // dwell stays frozen
            nxt_err  = 1'b1;
            nxt_code = ERR_LEAVE;
          end
        end
        default: ;                         // ERR is sticky, input ignored
      endcase
    end
  end

  // Registered state, flags and the previous sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      prev_c    <= '0;
      sat_pulse <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      st        <= nxt_st;
      prev_c    <= c_in;
      sat_pulse <= nxt_pulse;
      err       <= nxt_err;
      err_code  <= nxt_code;
    end
  end

  sat_dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clk (clk),
    .rst (rst),
    .clr (dw_clr),
    .en  (dw_en),
    .cnt (dwell_cnt)
  );

  assign state = st;

endmodule

// File: tb/tb_sat_count_monitor.sv
// Scoreboard bench: the driver pushes a hand-computed expectation for every
// clock edge it drives, a monitor pops and compares after each edge. A second
// instance with a 4-bit dwell counter shares the stimulus to show saturation.
module tb_sat_count_monitor;
  import sat_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [10:0] c_in = '0;
  logic [1:0]  state, state4;
  logic        sat_pulse, sat_pulse4, err, err4;
  logic [15:0] dwell_cnt;
  logic [3:0]  dwell4;
  logic [1:0]  err_code, err_code4;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      nm;
    logic [1:0] st;
    logic       p;
    logic [15:0] dw;
    logic [3:0] dw4;
    logic       e;
    logic [1:0] code;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  sat_count_monitor #(.W(11), .LIMIT(200), .DWELL_W(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .c_in(c_in), .state(state),
    .sat_pulse(sat_pulse), .dwell_cnt(dwell_cnt), .err(err), .err_code(err_code));

  sat_count_monitor #(.W(11), .LIMIT(200), .DWELL_W(4)) dut4 (
    .clk(clk), .rst(rst), .clr(clr), .c_in(c_in), .state(state4),
    .sat_pulse(sat_pulse4), .dwell_cnt(dwell4), .err(err4), .err_code(err_code4));

  task automatic compare(input exp_t x);
    checks++;
    if (state !== x.st || sat_pulse !== x.p || dwell_cnt !== x.dw || dwell4 !== x.dw4 ||
        err !== x.e || err_code !== x.code || state4 !== x.st || err_code4 !== x.code) begin
      errors++;
      $display("FAIL %s: got st=%0d p=%0b dw=%0d dw4=%0d err=%0b code=%0d st4=%0d code4=%0d; want st=%0d p=%0b dw=%0d dw4=%0d err=%0b code=%0d",
               x.nm, state, sat_pulse, dwell_cnt, dwell4, err, err_code, state4, err_code4,
               x.st, x.p, x.dw, x.dw4, x.e, x.code);
    end
  endtask

  // Monitor: every edge that has a pending expectation gets compared.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) compare(q.pop_front());
  end

  task automatic expect_next(input string nm, input logic [1:0] st, input logic p,
                             input int dw, input logic e, input logic [1:0] code);
    exp_t x;
    x.nm = nm; x.st = st; x.p = p; x.dw = 16'(dw);
    x.dw4 = (dw > 15) ? 4'd15 : 4'(dw);
    x.e = e; x.code = code;
    q.push_back(x);
  endtask

  task automatic step(input int c, input logic cl, input string nm, input logic [1:0] st,
                      input logic p, input int dw, input logic e, input logic [1:0] code);
    @(negedge clk);
    c_in = 11'(c);
    clr  = cl;
    expect_next(nm, st, p, dw, e, code);
  endtask

  // Direct check of outputs while no edge is involved (reset behaviour).
  task automatic check_now(input string nm, input logic [1:0] st);
    exp_t x;
    x.nm = nm; x.st = st; x.p = 1'b0; x.dw = '0; x.dw4 = '0; x.e = 1'b0; x.code = ERR_NONE;
    compare(x);
  endtask

  // Release reset mid-low-phase with c_in=0: IDLE now, RAMP after the edge.
  task automatic release_rst(input string nm);
    @(negedge clk);
    c_in = '0;
    clr  = 1'b0;
    rst  = 1'b1;
    #1 check_now({nm, "_idle"}, IDLE);
    expect_next({nm, "_ramp"}, RAMP, 1'b0, 0, 1'b0, ERR_NONE);
  endtask

  task automatic ramp_to_199(input string nm);
    for (int i = 1; i < 200; i++) step(i, 1'b0, nm, RAMP, 1'b0, 0, 1'b0, ERR_NONE);
  endtask

  initial begin
    // Reset state
    #12 check_now("reset", IDLE);
    release_rst("rel0");

    // Full ramp into saturation, then hold for 20 cycles
    ramp_to_199("ramp1");
    step(200, 1'b0, "sat_entry", SAT, 1'b1, 0, 1'b0, ERR_NONE);
    for (int k = 1; k <= 20; k++) step(200, 1'b0, "sat_hold", SAT, 1'b0, k, 1'b0, ERR_NONE);
    step(0, 1'b0, "sat_restart", RAMP, 1'b0, 0, 1'b0, ERR_NONE);

    // Over-range wins over bad step at prev_c=199
    ramp_to_199("ramp2");
    step(201, 1'b0, "over_range", ERR, 1'b0, 0, 1'b1, ERR_RANGE);
    step(202, 1'b0, "err_sticky1", ERR, 1'b0, 0, 1'b1, ERR_RANGE);
    step(0,   1'b0, "err_sticky2", ERR, 1'b0, 0, 1'b1, ERR_RANGE);
    step(0,   1'b1, "clr_range", IDLE, 1'b0, 0, 1'b0, ERR_NONE);

    // Bad step 5,6,8
    step(5, 1'b0, "idle_ignore", IDLE, 1'b0, 0, 1'b0, ERR_NONE);
    step(0, 1'b0, "idle_start", RAMP, 1'b0, 0, 1'b0, ERR_NONE);
    for (int i = 1; i <= 6; i++) step(i, 1'b0, "ramp3", RAMP, 1'b0, 0, 1'b0, ERR_NONE);
    step(8,   1'b0, "bad_step", ERR, 1'b0, 0, 1'b1, ERR_STEP);
    step(9,   1'b0, "step_sticky", ERR, 1'b0, 0, 1'b1, ERR_STEP);
    step(300, 1'b0, "step_sticky2", ERR, 1'b0, 0, 1'b1, ERR_STEP);
    step(0,   1'b1, "clr_step", IDLE, 1'b0, 0, 1'b0, ERR_NONE);

    // Leaving saturation freezes dwell
    step(0, 1'b0, "start4", RAMP, 1'b0, 0, 1'b0, ERR_NONE);
    ramp_to_199("ramp4");
    step(200, 1'b0, "sat_entry2", SAT, 1'b1, 0, 1'b0, ERR_NONE);
    step(200, 1'b0, "sat_dw1", SAT, 1'b0, 1, 1'b0, ERR_NONE);
    step(37,  1'b0, "leave_sat", ERR, 1'b0, 1, 1'b1, ERR_LEAVE);
    step(200, 1'b0, "leave_frozen", ERR, 1'b0, 1, 1'b1, ERR_LEAVE);
    step(0,   1'b1, "clr_leave", IDLE, 1'b0, 0, 1'b0, ERR_NONE);

    // clr on the same cycle as an illegal value
    step(0,  1'b0, "start5", RAMP, 1'b0, 0, 1'b0, ERR_NONE);
    step(1,  1'b0, "ramp5", RAMP, 1'b0, 0, 1'b0, ERR_NONE);
    step(50, 1'b1, "clr_vs_err", IDLE, 1'b0, 0, 1'b0, ERR_NONE);

    // Asynchronous reset mid-SAT
    step(0, 1'b0, "start6", RAMP, 1'b0, 0, 1'b0, ERR_NONE);
    ramp_to_199("ramp6");
    step(200, 1'b0, "sat_entry3", SAT, 1'b1, 0, 1'b0, ERR_NONE);
    step(200, 1'b0, "sat6_dw1", SAT, 1'b0, 1, 1'b0, ERR_NONE);
    step(200, 1'b0, "sat6_dw2", SAT, 1'b0, 2, 1'b0, ERR_NONE);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_now("async_rst", IDLE);
    release_rst("rel1");
    step(1, 1'b0, "after_rel", RAMP, 1'b0, 0, 1'b0, ERR_NONE);

    // Drain the scoreboard with a bounded wait
    for (int n = 0; n < 10 && q.size() > 0; n++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
